// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller front end: command codes,
// arbiter state encoding and address-width derivation.
package sdram_pkg;

    // Geometry of the attached part; the column count is in bytes and the
    // pitch converts bytes to 16-bit words.
    localparam int C_ROW_BITS   = 13;
    localparam int C_BANK_BITS  = 2;
    localparam int C_COL_BITS   = 9;
    localparam int C_PITCH_BITS = 1;
    localparam int C_AW_DEF     = C_ROW_BITS + C_BANK_BITS + C_COL_BITS - C_PITCH_BITS;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD1 = 2'b10;
    localparam logic [1:0] CMD_RD2 = 2'b11;

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_BUSY  = 2'd3
    } arb_state_t;

    // Width of a client index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker with optional fixed priority for
// requester 0. Searches upward from ptr, wrapping at N-1.
module rr_pick
    import sdram_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          prio0,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Scan from farthest to nearest so the first hit at or after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) idx = IW'(j);
        end
        if (prio0 && req[0]) idx = '0;
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-client front end sharing the SDRAM controller command port.
// Holds each grant until the controller acks, then steers the burst data
// strobes to the owning client with no added latency.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int C_NCLIENTS = 4,
    parameter int C_AW       = C_AW_DEF,
    parameter int C_PRIO0    = 1
) (
    input  logic                       sys_CLK,
    input  logic                       sys_nRST,
    input  logic [2*C_NCLIENTS-1:0]    cli_CMD,
    input  logic [C_AW*C_NCLIENTS-1:0] cli_ADDR,
    input  logic [16*C_NCLIENTS-1:0]   cli_DIN,
    output logic [C_NCLIENTS-1:0]      cli_ack,
    output logic [C_NCLIENTS-1:0]      cli_wr_data_valid,
    output logic [C_NCLIENTS-1:0]      cli_rd_data_valid,
    output logic [15:0]                cli_DOUT,
    output logic [1:0]                 sys_CMD,
    output logic [C_AW-1:0]            sys_ADDR,
    output logic [15:0]                sys_DIN,
    input  logic [15:0]                sys_DOUT,
    input  logic                       sys_rd_data_valid,
    input  logic                       sys_wr_data_valid,
    input  logic [1:0]                 sys_cmd_ack
);

    localparam int N  = C_NCLIENTS;
    localparam int IW = idx_width(N);

    arb_state_t    state, state_nx;
    logic [IW-1:0] owner, owner_nx, rr_ptr, rr_ptr_nx;
    logic [N-1:0]  owner_oh, owner_oh_nx;
    logic [1:0]    cmd_nx;
    logic [C_AW-1:0] addr_nx;
    logic [N-1:0]  ack_nx;
    logic [N-1:0]  req;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          ctrl_idle;
    logic          active;

    // A client is requesting whenever its command slice is non-NOP.
    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) req[i] = |cli_CMD[2*i +: 2];
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .prio0 (C_PRIO0 != 0),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign ctrl_idle = (sys_cmd_ack == CMD_NOP) && !sys_rd_data_valid && !sys_wr_data_valid;

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        owner_oh_nx = owner_oh;
        rr_ptr_nx   = rr_ptr;
        cmd_nx      = sys_CMD;
        addr_nx     = sys_ADDR;
        ack_nx      = '0;
        unique case (state)
            ST_DRAIN: begin
                cmd_nx = CMD_NOP;
                if (ctrl_idle) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                cmd_nx = CMD_NOP;
                if (pick_any) begin
                    owner_nx    = pick_idx;
                    owner_oh_nx = pick_gnt;
                    cmd_nx      = cli_CMD[2*pick_idx +: 2];
                    addr_nx     = cli_ADDR[C_AW*pick_idx +: C_AW];
                    state_nx    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sys_cmd_ack != CMD_NOP) begin
                    ack_nx    = owner_oh;
                    cmd_nx    = CMD_NOP;
                    rr_ptr_nx = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
                    state_nx  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cmd_nx = CMD_NOP;
                if (ctrl_idle) state_nx = ST_IDLE;
            end
            default: begin
                cmd_nx   = CMD_NOP;
                state_nx = ST_DRAIN;
            end
        endcase
    end

    // State and command-port registers; reset drains the controller first.
    always_ff @(posedge sys_CLK or negedge sys_nRST) begin
        if (!sys_nRST) begin
            state    <= ST_DRAIN;
            sys_CMD  <= CMD_NOP;
            sys_ADDR <= '0;
            cli_ack  <= '0;
            owner    <= '0;
            owner_oh <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nx;
            sys_CMD  <= cmd_nx;
            sys_ADDR <= addr_nx;
            cli_ack  <= ack_nx;
            owner    <= owner_nx;
            owner_oh <= owner_oh_nx;
            rr_ptr   <= rr_ptr_nx;
        end
    end

    assign active = (state == ST_ISSUE) || (state == ST_BUSY);

    // Route controller data strobes to the owner only while a grant is live.
    always_comb begin
        cli_wr_data_valid = '0;
        cli_rd_data_valid = '0;
        if (active) begin
            cli_wr_data_valid = owner_oh & {N{sys_wr_data_valid}};
            cli_rd_data_valid = owner_oh & {N{sys_rd_data_valid}};
        end
    end

    assign sys_DIN  = cli_DIN[16*owner +: 16];
    assign cli_DOUT = sys_DOUT;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a priority instance and a pure
// round-robin instance share the clients and a scripted controller model.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int N  = 4;
    localparam int AW = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    cl_cmd  [N];
    logic [AW-1:0] cl_addr [N];
    logic [15:0]   cl_din  [N];

    logic [2*N-1:0]  cli_CMD;
    logic [AW*N-1:0] cli_ADDR;
    logic [16*N-1:0] cli_DIN;

    logic [15:0] sys_DOUT;
    logic        sys_rd_data_valid, sys_wr_data_valid;
    logic [1:0]  sys_cmd_ack;

    logic [N-1:0]  cli_ack, cli_wr_data_valid, cli_rd_data_valid;
    logic [15:0]   cli_DOUT, sys_DIN;
    logic [1:0]    sys_CMD;
    logic [AW-1:0] sys_ADDR;

    logic [N-1:0]  rr_cli_ack, rr_cli_wr_data_valid, rr_cli_rd_data_valid;
    logic [15:0]   rr_cli_DOUT, rr_sys_DIN;
    logic [1:0]    rr_sys_CMD;
    logic [AW-1:0] rr_sys_ADDR;

    // Pack the per-client arrays onto the flat buses.
    always_comb begin
        cli_CMD  = '0;
        cli_ADDR = '0;
        cli_DIN  = '0;
        for (int i = 0; i < N; i++) begin
            cli_CMD[2*i +: 2]    = cl_cmd[i];
            cli_ADDR[AW*i +: AW] = cl_addr[i];
            cli_DIN[16*i +: 16]  = cl_din[i];
        end
    end

    sdram_arbiter #(.C_NCLIENTS(N), .C_AW(AW), .C_PRIO0(1)) dut (
        .sys_CLK(clk), .sys_nRST(rst_n),
        .cli_CMD(cli_CMD), .cli_ADDR(cli_ADDR), .cli_DIN(cli_DIN),
        .cli_ack(cli_ack), .cli_wr_data_valid(cli_wr_data_valid),
        .cli_rd_data_valid(cli_rd_data_valid), .cli_DOUT(cli_DOUT),
        .sys_CMD(sys_CMD), .sys_ADDR(sys_ADDR), .sys_DIN(sys_DIN),
        .sys_DOUT(sys_DOUT), .sys_rd_data_valid(sys_rd_data_valid),
        .sys_wr_data_valid(sys_wr_data_valid), .sys_cmd_ack(sys_cmd_ack)
    );

    sdram_arbiter #(.C_NCLIENTS(N), .C_AW(AW), .C_PRIO0(0)) dut_rr (
        .sys_CLK(clk), .sys_nRST(rst_n),
        .cli_CMD(cli_CMD), .cli_ADDR(cli_ADDR), .cli_DIN(cli_DIN),
        .cli_ack(rr_cli_ack), .cli_wr_data_valid(rr_cli_wr_data_valid),
        .cli_rd_data_valid(rr_cli_rd_data_valid), .cli_DOUT(rr_cli_DOUT),
        .sys_CMD(rr_sys_CMD), .sys_ADDR(rr_sys_ADDR), .sys_DIN(rr_sys_DIN),
        .sys_DOUT(sys_DOUT), .sys_rd_data_valid(sys_rd_data_valid),
        .sys_wr_data_valid(sys_wr_data_valid), .sys_cmd_ack(sys_cmd_ack)
    );

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];
    int exp_rr_q[$];
    bit chk_rr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sys_CMD != CMD_NOP) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_eq("grant_seen", {31'd0, ok}, 32'd1);
    endtask

    // Controller model for one transaction: ack for ack_len cycles, data
    // beats starting the cycle after the first ack.
    task automatic txn(input logic [1:0] ackcode, input int ack_len, input int beats, input bit is_rd);
        bit ok;
        int o, orr, total;
        orr = 0;
        wait_cmd(ok);
        if (!ok) return;
        o = exp_q.pop_front();
        check_eq("grant_cmd", sys_CMD, cl_cmd[o]);
        check_eq("grant_addr", sys_ADDR, cl_addr[o]);
        if (chk_rr) begin
            orr = exp_rr_q.pop_front();
            check_eq("rr_grant_cmd", rr_sys_CMD, cl_cmd[orr]);
            check_eq("rr_grant_addr", rr_sys_ADDR, cl_addr[orr]);
        end
        total = (ack_len > beats + 1) ? ack_len : beats + 1;
        for (int c = 0; c < total; c++) begin
            sys_cmd_ack       = (c < ack_len) ? ackcode : CMD_NOP;
            sys_rd_data_valid = is_rd && (c >= 1) && (c <= beats);
            sys_wr_data_valid = !is_rd && (c >= 1) && (c <= beats);
            sys_DOUT          = 16'($urandom);
            #1;
            if (c >= 1 && c <= beats) begin
                if (is_rd) begin
                    check_eq("rd_route", cli_rd_data_valid, 32'(1) << o);
                    check_eq("rd_data", cli_DOUT, sys_DOUT);
                    if (chk_rr) check_eq("rr_rd_route", rr_cli_rd_data_valid, 32'(1) << orr);
                end else begin
                    check_eq("wr_route", cli_wr_data_valid, 32'(1) << o);
                    check_eq("wr_din", sys_DIN, cl_din[o]);
                end
            end
            if (c >= 1) check_eq("no_cmd_in_burst", sys_CMD, CMD_NOP);
            tick();
            if (c == 0) begin
                check_eq("ack_pulse", cli_ack, 32'(1) << o);
                if (chk_rr) check_eq("rr_ack_pulse", rr_cli_ack, 32'(1) << orr);
            end else if (c == 1) begin
                check_eq("ack_single", cli_ack, 0);
            end
        end
        sys_cmd_ack       = CMD_NOP;
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < N; i++) begin
            cl_cmd[i]  = CMD_NOP;
            cl_addr[i] = AW'(32'h0100 * (i + 1) + i);
            cl_din[i]  = 16'hA000 + 16'(i * 16'h0111);
        end
        cl_addr[1] = 23'h0ABCD;
        cl_addr[2] = 23'h12345;
        cl_din[2]  = 16'hBEEF;
        sys_DOUT = '0;
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
        sys_cmd_ack = CMD_NOP;

        // Reset with the controller still busy from a previous life.
        #1 rst_n = 1'b0;
        sys_cmd_ack = 2'b10;
        sys_rd_data_valid = 1'b1;
        cl_cmd[1] = CMD_RD1;
        tick();
        tick();
        check_eq("rst_sys_cmd", sys_CMD, CMD_NOP);
        check_eq("rst_sys_addr", sys_ADDR, 0);
        check_eq("rst_cli_ack", cli_ack, 0);
        check_eq("rst_rd_valid", cli_rd_data_valid, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("drain_sys_cmd", sys_CMD, CMD_NOP);
            check_eq("drain_rd_valid", cli_rd_data_valid, 0);
            check_eq("drain_rr_sys_cmd", rr_sys_CMD, CMD_NOP);
        end
        sys_cmd_ack = CMD_NOP;
        sys_rd_data_valid = 1'b0;
        exp_q.push_back(1);
        txn(2'b10, 1, 2, 1'b1);
        cl_cmd[1] = CMD_NOP;

        // Single write from client 2.
        cl_cmd[2] = CMD_WR;
        exp_q.push_back(2);
        txn(2'b01, 1, 4, 1'b0);
        cl_cmd[2] = CMD_NOP;

        // All clients read continuously: rotation vs. client-0 priority.
        reset_dut();
        for (int i = 0; i < N; i++) cl_cmd[i] = CMD_RD1;
        chk_rr = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp_q.push_back(0);
            exp_rr_q.push_back(t % N);
            txn(2'b10, 1, 2, 1'b1);
        end
        chk_rr = 1'b0;
        for (int i = 0; i < N; i++) cl_cmd[i] = CMD_NOP;

        // Clients 1 and 3 continuous, client 0 on every third transaction.
        reset_dut();
        cl_cmd[1] = CMD_RD1;
        cl_cmd[3] = CMD_RD1;
        for (int t = 0; t < 7; t++) begin
            if (t % 3 == 2) cl_cmd[0] = CMD_RD1;
            case (t % 3)
                0: exp_q.push_back(1);
                1: exp_q.push_back(3);
                default: exp_q.push_back(0);
            endcase
            txn(2'b10, 1, 2, 1'b1);
            cl_cmd[0] = CMD_NOP;
        end
        cl_cmd[1] = CMD_NOP;
        cl_cmd[3] = CMD_NOP;

        // Long read whose ack drops four cycles before the last beat.
        reset_dut();
        cl_cmd[1] = CMD_RD2;
        cl_cmd[3] = CMD_RD1;
        exp_q.push_back(1);
        txn(2'b10, 124, 128, 1'b1);
        cl_cmd[1] = CMD_NOP;
        exp_q.push_back(3);
        txn(2'b10, 1, 2, 1'b1);
        cl_cmd[3] = CMD_NOP;

        // Reset in the middle of a client 1 write burst.
        reset_dut();
        cl_cmd[1] = CMD_WR;
        wait_cmd(ok);
        check_eq("mb_grant_addr", sys_ADDR, cl_addr[1]);
        sys_cmd_ack = 2'b01;
        tick();
        check_eq("mb_ack", cli_ack, 32'd2);
        sys_cmd_ack = CMD_NOP;
        sys_wr_data_valid = 1'b1;
        #1;
        check_eq("mb_wr_route", cli_wr_data_valid, 32'd2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mb_rst_sys_cmd", sys_CMD, CMD_NOP);
        check_eq("mb_rst_sys_addr", sys_ADDR, 0);
        check_eq("mb_rst_cli_ack", cli_ack, 0);
        check_eq("mb_rst_wr_valid", cli_wr_data_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("mb_drain_sys_cmd", sys_CMD, CMD_NOP);
            check_eq("mb_drain_wr_valid", cli_wr_data_valid, 0);
        end
        sys_wr_data_valid = 1'b0;
        exp_q.push_back(1);
        txn(2'b01, 1, 2, 1'b0);
        cl_cmd[1] = CMD_NOP;

        check_eq("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
